muldiv_seq: RTL and testbench

- Multi-cycle sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Replaces the single-cycle combinational `*`, `/` and `%` paths, which are too slow for timing closure.
- Sits beside the ALU. The control FSM issues a request when opcode is R-type and func7[0]=1, then stalls until `done`.
- Internally a radix-2 shift-add multiplier and a restoring divider, sharing one 33-bit adder, sequenced by a small FSM.

---
 rtl/muldiv_pkg.sv | 48 ++++
 rtl/muldiv_seq_if.sv | 26 ++
 rtl/muldiv_step.sv | 53 +++++
 rtl/muldiv_seq.sv | 174 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, constants and op-decode helpers for the RV32M sequencer
//   muldiv_op_e    : op select, encoded exactly as func3
//   muldiv_state_e : sequencer states
//   DIV0_QUOT      : quotient returned for a divide by zero
//   INT_MIN        : most negative XLEN-bit value (signed-divide overflow case)
package muldiv_pkg;

  localparam int MULDIV_XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam logic [MULDIV_XLEN-1:0] DIV0_QUOT = '1;
  localparam logic [MULDIV_XLEN-1:0] INT_MIN   = {1'b1, {(MULDIV_XLEN-1){1'b0}}};

  function automatic logic is_div(muldiv_op_e op);
    logic [2:0] f;
    f = op;
    return f[2];
  endfunction

  // op1 is interpreted as signed
  function automatic logic is_signed(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // op2 is interpreted as signed (MULHSU takes op2 unsigned)
  function automatic logic is_signed_op2(muldiv_op_e op);
    return is_signed(op) && (op != OP_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between the control FSM and the mul/div sequencer
//   master (requester): drives req_valid, func3, op1, op2, kill; sees req_ready, busy, done, result
//   slave  (sequencer): the reverse
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, func3, op1, op2, kill,
    input  req_ready, busy, done, result
  );

  modport slave (
    input  req_valid, func3, op1, op2, kill,
    output req_ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (multiply) or restoring (divide) iteration on a shared adder
//   is_div     : 1 = divide step, 0 = multiply step
//   hi, lo     : multiply: product {hi,lo}, multiplier in lo; divide: remainder in hi, dividend/quotient in lo
//   b          : multiplicand or divisor magnitude
//   hi_n, lo_n : register values after this iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);

  logic [XLEN:0] a_op;
  logic [XLEN:0] b_op;
  logic [XLEN:0] cin;
  logic [XLEN:0] sum;

  always_comb begin
    a_op = '0;
    b_op = '0;
    cin  = '0;
    hi_n = hi;
    lo_n = lo;
    if (is_div) begin
      // Shifted remainder can be 33 bits wide; bit XLEN of the difference is the borrow.
      a_op = {hi, lo[XLEN-1]};
      b_op = ~{1'b0, b};
      cin  = {{XLEN{1'b0}}, 1'b1};
    end else begin
      a_op = {1'b0, hi};
      b_op = lo[0] ? {1'b0, b} : '0;
    end
    sum = a_op + b_op + cin;
    if (is_div) begin
      if (!sum[XLEN]) begin
        hi_n = sum[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = a_op[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Carry out of the add becomes the new product MSB as everything shifts right.
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer
//   clk : rising-edge clock       rst : synchronous active-high reset
//   bus : muldiv_seq_if.slave (req_valid/req_ready/func3/op1/op2/kill in, busy/done/result out)
//   MULDIV_EARLY_OUT_EN : when defined, multiplies leave CALC once the remaining multiplier bits are zero
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0] res_pend_q, res_pend_d, result_q, result_d;
  logic            neg_q, neg_d, sign_a_q, sign_a_d;

  // Accept-side decode
  muldiv_op_e      op_in;
  logic            a_neg, b_neg, fast_hit;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign op_in    = muldiv_op_e'(bus.func3);
  assign a_neg    = is_signed(op_in) && bus.op1[XLEN-1];
  assign b_neg    = is_signed_op2(op_in) && bus.op2[XLEN-1];
  assign a_mag    = a_neg ? -bus.op1 : bus.op1;
  assign b_mag    = b_neg ? -bus.op2 : bus.op2;
  assign fast_hit = is_div(op_in) &&
                    ((bus.op2 == '0) ||
                     ((op_in == OP_DIV || op_in == OP_REM) && bus.op1 == INT_MIN && bus.op2 == DIV0_QUOT));
  // func3[1] separates REM* from DIV*
  assign fast_res = (bus.op2 == '0) ? (bus.func3[1] ? bus.op1 : DIV0_QUOT)
                                    : (bus.func3[1] ? '0 : INT_MIN);

  logic            div_op_q;
  logic [XLEN-1:0] hi_n, lo_n;
  assign div_op_q = is_div(op_q);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (div_op_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .b      (b_q),
    .hi_n   (hi_n),
    .lo_n   (lo_n)
  );

  // Sign fix-up and half select
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, quot, rem, div_res;
`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W:0]    shamt;
  logic [XLEN-1:0]   rem_mask;
  // Skipped iterations were pure right shifts, so apply them in one go.
  assign shamt    = (CNT_W+1)'(XLEN) - {1'b0, cnt_q};
  assign prod     = {hi_q, lo_q} >> shamt;
  // Multiplier bits still unconsumed after this cycle's step
  assign rem_mask = {XLEN{1'b1}} >> (cnt_q + CNT_W'(1));
`else
  assign prod     = {hi_q, lo_q};
`endif
  assign prod_s  = neg_q ? -prod : prod;
  assign mul_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign quot    = neg_q ? -lo_q : lo_q;
  assign rem     = sign_a_q ? -hi_q : hi_q;
  assign div_res = op_q[1] ? rem : quot;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    neg_d      = neg_q;
    sign_a_d   = sign_a_q;
    res_pend_d = res_pend_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = op_in;
          cnt_d    = '0;
          hi_d     = '0;
          neg_d    = a_neg ^ b_neg;
          sign_a_d = a_neg;
          if (is_div(op_in)) begin
            lo_d = a_mag;
            b_d  = b_mag;
          end else begin
            lo_d = b_mag;
            b_d  = a_mag;
          end
          if (fast_hit) begin
            res_pend_d = fast_res;
            state_d    = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          hi_d  = hi_n;
          lo_d  = lo_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = FIX;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!div_op_q && ((lo_n & rem_mask) == '0)) begin
            state_d = FIX;
          end
`endif
        end
      end
      FIX: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else begin
          res_pend_d = div_op_q ? div_res : mul_res;
          state_d    = DONE;
        end
      end
      DONE: begin
        // Commit to the held result only if not killed on the way out.
        if (!bus.kill) begin
          result_d = res_pend_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      sign_a_q   <= 1'b0;
      res_pend_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      sign_a_q   <= sign_a_d;
      res_pend_q <= res_pend_d;
      result_q   <= result_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC) || (state_q == FIX);
  assign bus.done      = (state_q == DONE) && !bus.kill;
  assign bus.result    = ((state_q == DONE) && !bus.kill) ? res_pend_q : result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [31:0] MINV = 32'h8000_0000;

  function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint          sa, sb, ub, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = longint'({32'b0, a}) * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [31:0] m;
    int          it;
    if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f[2]) begin
      m  = (f <= 3'd1 && b[31]) ? -b : b;
      it = 1;
      for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
      return it + 2;
    end
`else
    m  = 0;
    it = 0;
`endif
    return 34;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: what the sequencer must be doing, from accept/kill/reset events only.
  bit          mvalid = 0;
  bit          inflight = 0;
  int          acc_cyc = 0;
  int          m_lat = 0;
  logic [31:0] m_res = 0;
  logic [31:0] last_res = 0;

  always @(negedge clk) begin
    int          k;
    bit          e_done, e_busy, e_ready, was_idle;
    logic [31:0] e_res;
    k = 0;
    e_done = 0;
    e_busy = 0;
    e_ready = 1;
    if (mvalid) begin
      if (inflight) begin
        k       = cyc - acc_cyc;
        e_ready = 0;
        e_busy  = (m_lat > 1) && (k <= m_lat - 1);
        e_done  = (k == m_lat) && !bus.kill;
      end
      e_res = e_done ? m_res : last_res;
      chk("req_ready", {31'b0, bus.req_ready}, {31'b0, e_ready});
      chk("busy", {31'b0, bus.busy}, {31'b0, e_busy});
      chk("done", {31'b0, bus.done}, {31'b0, e_done});
      chk("result", bus.result, e_res);
    end
    if (rst) begin
      mvalid   = 1;
      inflight = 0;
      last_res = 0;
    end else if (mvalid) begin
      was_idle = !inflight;
      if (inflight) begin
        if (bus.kill) inflight = 0;
        else if (k == m_lat) begin
          last_res = m_res;
          inflight = 0;
        end
      end
      if (was_idle && bus.req_valid) begin
        inflight = 1;
        acc_cyc  = cyc;
        m_res    = ref_op(bus.func3, bus.op1, bus.op2);
        m_lat    = lat_of(bus.func3, bus.op1, bus.op2);
      end
    end
  end

  task automatic send(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    int n;
    bus.func3     = f;
    bus.op1       = a;
    bus.op2       = b;
    bus.req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no req_ready, required within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL done_timeout: got no done, required within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL idle_timeout: got req_ready=0, required 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    bus.func3     = 3'd0;
    bus.op1       = 32'h0;
    bus.op2       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Hand-computed values pin the model
    chk("ref_mul_7_m3", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("ref_mulhu_m1", ref_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("ref_mulh_m1", ref_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0);
    chk("ref_mulhsu_m1", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("ref_div_m7_2", ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("ref_rem_m7_2", ref_op(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("ref_divu_100_7", ref_op(3'd5, 32'd100, 32'd7), 32'd14);
    chk("ref_remu_100_7", ref_op(3'd7, 32'd100, 32'd7), 32'd2);
    chk("ref_divu_by0", ref_op(3'd5, 32'd5, 32'd0), 32'hFFFF_FFFF);
    chk("ref_remu_by0", ref_op(3'd7, 32'd5, 32'd0), 32'd5);
    chk("ref_div_ovf", ref_op(3'd4, MINV, 32'hFFFF_FFFF), MINV);
    chk("ref_rem_ovf", ref_op(3'd6, MINV, 32'hFFFF_FFFF), 32'h0);
    chk("ref_lat_div", 32'(lat_of(3'd4, 32'd100, 32'd7)), 32'd34);
    chk("ref_lat_fast", 32'(lat_of(3'd5, 32'd5, 32'd0)), 32'd1);

    // Directed operations from the plan; the monitor checks timing and values
    send(3'd0, 32'd7, 32'hFFFF_FFFD);        wait_done();
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    send(3'd4, 32'hFFFF_FFF9, 32'd2);        wait_done();
    send(3'd6, 32'hFFFF_FFF9, 32'd2);        wait_done();
    send(3'd5, 32'd100, 32'd7);              wait_done();
    send(3'd7, 32'd100, 32'd7);              wait_done();
    send(3'd5, 32'd5, 32'd0);                wait_done();
    send(3'd7, 32'd5, 32'd0);                wait_done();
    send(3'd4, MINV, 32'hFFFF_FFFF);         wait_done();
    send(3'd6, MINV, 32'hFFFF_FFFF);         wait_done();

    // Kill in cycle 10 of a MUL, then a fresh MUL
    send(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    send(3'd0, 32'd3, 32'd4); wait_done();
    chk("mul_3x4_held", bus.result, 32'd12);

    // Kill during DONE of a fast-path op
    send(3'd5, 32'd9, 32'd0);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    wait_idle();

    // Reset in the middle of a DIV
    send(3'd4, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_result", bus.result, 32'h0);
    @(posedge clk);
    #1;

    // req_valid held high: one accept per IDLE visit
    bus.func3     = 3'd1;
    bus.op1       = 32'hDEAD_BEEF;
    bus.op2       = 32'h0BAD_F00D;
    bus.req_valid = 1'b1;
    repeat (110) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_idle();

    // Second request presented while busy
    send(3'd5, 32'd77, 32'd5);
    send(3'd7, 32'd77, 32'd5);
    wait_done();

    // Randomized operations with occasional kills
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bus.kill = 1'b1;
      send(f, pick(), pick());
      bus.kill = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 36)) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
